// File: rtl/synth_voice.sv
// Single synthesizer voice: phase-accumulator oscillator, noise LFSR and ADSR envelope.
// Produces an offset-binary pcm sample one clock after every sample tick.
module synth_voice #(
    parameter int unsigned SAMPLE_DIV = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gate,
    input  logic [15:0] freq_inc,
    input  logic [1:0]  wave_sel,
    input  logic [7:0]  attack_rate,
    input  logic [7:0]  decay_rate,
    input  logic [7:0]  release_rate,
    input  logic [7:0]  sustain_lvl,
    output logic [15:0] pcm,
    output logic        sample_stb,
    output logic        active
);

    localparam int unsigned DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] SILENCE   = 16'h8000;
    localparam logic [15:0] ENV_MAX   = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

    logic [DIV_W-1:0] div_q, div_d;
    logic [15:0]      phase_q, phase_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [15:0]      env_q, env_d;
    env_state_t       state_q, state_d;
    logic             pend_q, pend_d;
    logic [15:0]      pcm_q, pcm_d;
    logic             stb_q, stb_d;
    logic             active_q, active_d;

    logic               tick;
    logic [16:0]        phase_sum;
    logic               lfsr_fb;
    logic [15:0]        step_a, step_d, step_r, sus_lvl;
    logic [16:0]        atk_sum;
    logic [15:0]        wave;
    logic signed [15:0] samp_s;
    logic signed [16:0] env_s;
    logic signed [31:0] prod;
    logic               unused_prod_lo;

    // Next-state: divider, oscillator, envelope and output sample
    always_comb begin
        div_d    = div_q + DIV_W'(1);
        phase_d  = phase_q;
        lfsr_d   = lfsr_q;
        env_d    = env_q;
        state_d  = state_q;
        pend_d   = 1'b0;
        pcm_d    = pcm_q;
        stb_d    = pend_q;
        active_d = active_q;

        tick      = (div_q == DIV_LAST);
        phase_sum = {1'b0, phase_q} + {1'b0, freq_inc};
        lfsr_fb   = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        step_a    = {attack_rate, 8'h00};
        step_d    = {decay_rate, 8'h00};
        step_r    = {release_rate, 8'h00};
        sus_lvl   = {sustain_lvl, 8'h00};
        atk_sum   = {1'b0, env_q} + {1'b0, step_a};

        if (tick) begin
            div_d   = '0;
            pend_d  = 1'b1;
            phase_d = phase_sum[15:0];
            if (phase_sum[16]) begin
                lfsr_d = {lfsr_fb, lfsr_q[15:1]};
            end
            // Gate transitions take priority and leave env untouched
            unique case (state_q)
                ST_IDLE: begin
                    if (gate) state_d = ST_ATTACK;
                    else      env_d   = '0;
                end
                ST_ATTACK: begin
                    if (!gate) begin
                        state_d = ST_RELEASE;
                    end else if (attack_rate != 8'h00) begin
                        if (atk_sum >= {1'b0, ENV_MAX}) begin
                            env_d   = ENV_MAX;
                            state_d = ST_DECAY;
                        end else begin
                            env_d = atk_sum[15:0];
                        end
                    end
                end
                ST_DECAY: begin
                    if (!gate) begin
                        state_d = ST_RELEASE;
                    end else if (decay_rate != 8'h00) begin
                        if ((env_q <= sus_lvl) || ((env_q - sus_lvl) <= step_d)) begin
                            env_d   = sus_lvl;
                            state_d = ST_SUSTAIN;
                        end else begin
                            env_d = env_q - step_d;
                        end
                    end
                end
                ST_SUSTAIN: begin
                    if (!gate) state_d = ST_RELEASE;
                    else       env_d   = sus_lvl;
                end
                ST_RELEASE: begin
                    if (gate) begin
                        state_d = ST_ATTACK;
                    end else if (release_rate != 8'h00) begin
                        if (env_q <= step_r) begin
                            env_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            env_d = env_q - step_r;
                        end
                    end
                end
                default: begin
                    env_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
        active_d = (state_d != ST_IDLE);

        unique case (wave_sel)
            2'd0:    wave = phase_q;
            2'd1:    wave = phase_q[15] ? 16'h0000 : 16'hFFFF;
            2'd2:    wave = phase_q[15] ? ~{phase_q[14:0], 1'b0} : {phase_q[14:0], 1'b0};
            default: wave = lfsr_q;
        endcase

        // Signed waveform times unsigned envelope; the product always fits 32 bits
        samp_s         = $signed(wave ^ SILENCE);
        env_s          = $signed({1'b0, env_q});
        prod           = 32'(samp_s) * 32'(env_s);
        unused_prod_lo = ^prod[15:0];
        if (pend_q) begin
            pcm_d = prod[31:16] ^ SILENCE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q    <= '0;
            phase_q  <= '0;
            lfsr_q   <= LFSR_SEED;
            env_q    <= '0;
            state_q  <= ST_IDLE;
            pend_q   <= 1'b0;
            pcm_q    <= SILENCE;
            stb_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            phase_q  <= phase_d;
            lfsr_q   <= lfsr_d;
            env_q    <= env_d;
            state_q  <= state_d;
            pend_q   <= pend_d;
            pcm_q    <= pcm_d;
            stb_q    <= stb_d;
            active_q <= active_d;
        end
    end

    assign pcm        = pcm_q;
    assign sample_stb = stb_q;
    assign active     = active_q;

endmodule

// File: tb/tb_synth_voice.sv
// Bench for synth_voice (SAMPLE_DIV=4): directed and random stimulus checked
// against an arithmetic model of the voice evaluated once per sample tick.
module tb_synth_voice;

    localparam int unsigned DIV = 4;
    localparam int M_IDLE = 0;
    localparam int M_ATK  = 1;
    localparam int M_DEC  = 2;
    localparam int M_SUS  = 3;
    localparam int M_REL  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        gate;
    logic [15:0] freq_inc;
    logic [1:0]  wave_sel;
    logic [7:0]  attack_rate, decay_rate, release_rate, sustain_lvl;
    logic [15:0] pcm;
    logic        sample_stb;
    logic        active;

    synth_voice #(.SAMPLE_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .gate(gate), .freq_inc(freq_inc),
        .wave_sel(wave_sel), .attack_rate(attack_rate), .decay_rate(decay_rate),
        .release_rate(release_rate), .sustain_lvl(sustain_lvl),
        .pcm(pcm), .sample_stb(sample_stb), .active(active)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int exp_gap = 5;

    int          m_phase, m_env, m_st;
    logic [15:0] m_lfsr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic void m_reset();
        m_phase = 0;
        m_env   = 0;
        m_st    = M_IDLE;
        m_lfsr  = 16'hACE1;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One sample tick of the voice, straight from the behavioural rules
    function automatic void m_tick();
        int sum, a, d, r, s;
        sum = m_phase + int'(freq_inc);
        m_phase = sum % 65536;
        if (sum > 65535) m_lfsr = {^(m_lfsr & 16'h002D), m_lfsr[15:1]};
        a = int'(attack_rate) * 256;
        d = int'(decay_rate) * 256;
        r = int'(release_rate) * 256;
        s = int'(sustain_lvl) * 256;
        case (m_st)
            M_IDLE: if (gate) m_st = M_ATK; else m_env = 0;
            M_ATK: begin
                if (!gate) m_st = M_REL;
                else if (a > 0) begin
                    m_env = (m_env + a > 65535) ? 65535 : m_env + a;
                    if (m_env == 65535) m_st = M_DEC;
                end
            end
            M_DEC: begin
                if (!gate) m_st = M_REL;
                else if (d > 0) begin
                    m_env = imax(m_env - d, s);
                    if (m_env == s) m_st = M_SUS;
                end
            end
            M_SUS: if (!gate) m_st = M_REL; else m_env = s;
            default: begin
                if (gate) m_st = M_ATK;
                else if (r > 0) begin
                    m_env = imax(m_env - r, 0);
                    if (m_env == 0) m_st = M_IDLE;
                end
            end
        endcase
    endfunction

    function automatic logic [15:0] m_pcm();
        int w;
        longint p;
        case (wave_sel)
            2'd0: w = m_phase;
            2'd1: w = (m_phase >= 32768) ? 0 : 65535;
            2'd2: begin
                w = (m_phase * 2) % 65536;
                if (m_phase >= 32768) w = 65535 - w;
            end
            default: w = int'(m_lfsr);
        endcase
        p = longint'(w - 32768) * longint'(m_env);
        p = p >>> 16;
        return 16'(p) ^ 16'h8000;
    endfunction

    // Wait for the next strobe (bounded), then check timing, sample and activity
    task automatic next_sample(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n = n + 1;
        end while (sample_stb !== 1'b1 && n < 12);
        chk({tag, "_gap"}, 32'(n), 32'(exp_gap));
        exp_gap = 4;
        m_tick();
        chk({tag, "_pcm"}, 32'(pcm), 32'(m_pcm()));
        chk({tag, "_act"}, 32'(active), 32'(m_st != M_IDLE));
    endtask

    task automatic run_until(input int st, input string tag);
        for (int i = 0; i < 40 && m_st != st; i++) next_sample(tag);
    endtask

    initial begin
        rst_n = 1'b0; gate = 1'b0; freq_inc = '0; wave_sel = '0;
        attack_rate = '0; decay_rate = '0; release_rate = '0; sustain_lvl = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pcm", 32'(pcm), 32'h8000);
        chk("rst_stb", 32'(sample_stb), 32'h0);
        chk("rst_act", 32'(active), 32'h0);
        rst_n = 1'b1;
        m_reset();
        exp_gap = 5;

        // Attack to full scale, then hold in decay with a zero decay rate
        gate = 1'b1; wave_sel = 2'd0; freq_inc = 16'h1000;
        attack_rate = 8'hFF; decay_rate = 8'h00; sustain_lvl = 8'h40;
        repeat (5) next_sample("atk");

        // Decay to sustain, track a sustain level change, then release to idle
        decay_rate = 8'h10;
        run_until(M_SUS, "dec");
        next_sample("sus");
        sustain_lvl = 8'h50;
        repeat (2) next_sample("sus_trk");
        gate = 1'b0; release_rate = 8'h20;
        run_until(M_IDLE, "rel");
        repeat (2) next_sample("idle");

        // Retrigger from the middle of release
        gate = 1'b1; decay_rate = 8'h40; sustain_lvl = 8'h40; wave_sel = 2'd2;
        run_until(M_SUS, "re_sus");
        gate = 1'b0; release_rate = 8'h10;
        repeat (2) next_sample("re_rel");
        gate = 1'b1; attack_rate = 8'h20; wave_sel = 2'd0;
        repeat (3) next_sample("re_atk");

        // Noise: wrap every tick advances the LFSR, a tiny increment holds it
        attack_rate = 8'hFF; decay_rate = 8'h00; wave_sel = 2'd3; freq_inc = 16'hFFFF;
        run_until(M_DEC, "nz_up");
        repeat (6) next_sample("nz_run");
        freq_inc = 16'h0001;
        repeat (3) next_sample("nz_hold");
        wave_sel = 2'd1; freq_inc = 16'h3000;
        repeat (3) next_sample("sq");

        // Reset landing on a tick edge while sustaining
        decay_rate = 8'h80; sustain_lvl = 8'h60; wave_sel = 2'd0; freq_inc = 16'h0700;
        run_until(M_SUS, "mr_sus");
        next_sample("mr_pre");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_pcm", 32'(pcm), 32'h8000);
        chk("mrst_stb", 32'(sample_stb), 32'h0);
        chk("mrst_act", 32'(active), 32'h0);
        rst_n = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
        chk("mrst_stb2", 32'(sample_stb), 32'h0);
        exp_gap = 4;
        repeat (3) next_sample("mr_post");

        // Random inputs, changed right after each strobe
        for (int i = 0; i < 60; i++) begin
            gate         = ($urandom_range(0, 4) != 0);
            wave_sel     = 2'($urandom);
            freq_inc     = 16'($urandom);
            attack_rate  = 8'($urandom);
            decay_rate   = 8'($urandom);
            release_rate = 8'($urandom);
            sustain_lvl  = 8'($urandom);
            next_sample("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
